// File: rtl/av_pkg.sv
// Shared types for the AV control sequencer: operating modes, gesture codes
// and the button press state machine encoding.
package av_pkg;

  typedef enum logic [1:0] {
    GESTURE = 2'd0,
    VOLUME  = 2'd1,
    FREQ    = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } gesture_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } press_t;

  function automatic mode_t next_mode(mode_t m);
    case (m)
      GESTURE: return VOLUME;
      VOLUME:  return FREQ;
      default: return GESTURE;
    endcase
  endfunction

endpackage

// File: rtl/av_control_unit_if.sv
// Gesture event handshake between the gesture decoder (master) and the
// control unit (slave).
interface av_gesture_if;
  import av_pkg::*;

  logic     gesture_valid;
  gesture_t gesture;
  logic     gesture_ready;

  modport master (output gesture_valid, output gesture, input gesture_ready);
  modport slave  (input gesture_valid, input gesture, output gesture_ready);
endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus debounce counter for the active-low button.
// flip is high on the edge where the debounced level is about to toggle.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clock,
  input  logic nReset,
  input  logic button,
  output logic level,
  output logic flip
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  assign flip = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        cnt   <= '0;
        level <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/av_control_unit.sv
// Control sequencer: button press classification, mode stepping, and gesture
// driven volume / BCD frequency settings for the display encoders.
module av_control_unit
  import av_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 16,
  parameter int VOL_MAX           = 7,
  parameter int VOL_DEFAULT       = 3,
  parameter int FREQ_DEFAULT      = 50
) (
  input  logic         Clock,
  input  logic         nReset,
  input  logic         button,
  av_gesture_if.slave  gif,
  output mode_t        mode,
  output logic [2:0]   volume,
  output logic [6:0]   volume_leds,
  output logic [3:0]   freq_tens,
  output logic [3:0]   freq_ones,
  output gesture_t     last_gesture,
  output logic         cfg_strobe
);
  localparam int HW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [3:0] TENS_DEF = 4'(FREQ_DEFAULT / 10);
  localparam logic [3:0] ONES_DEF = 4'(FREQ_DEFAULT % 10);

  function automatic logic [2:0] vol_up(logic [2:0] v);
    return (v >= 3'(VOL_MAX)) ? 3'(VOL_MAX) : v + 3'd1;
  endfunction

  function automatic logic [2:0] vol_dn(logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  function automatic logic [6:0] thermo(logic [2:0] v);
    logic [6:0] t;
    for (int i = 0; i < 7; i++) t[i] = (v > 3'(i));
    return t;
  endfunction

  function automatic logic [3:0] dig_up(logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] dig_dn(logic [3:0] d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  logic          deb_level, deb_flip;
  logic          press_evt, release_evt, short_evt, long_evt;
  press_t        pstate;
  logic [HW-1:0] hold_cnt;
  logic          ready_q, accept;
  logic [2:0]    vol_n;
  logic [3:0]    tens_n, ones_n;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .Clock  (Clock),
    .nReset (nReset),
    .button (button),
    .level  (deb_level),
    .flip   (deb_flip)
  );

  // Debounced level is active-low: a flip from 1 is a press, from 0 a release.
  assign press_evt   = deb_flip &&  deb_level;
  assign release_evt = deb_flip && !deb_level;
  assign short_evt   = (pstate == HELD) && release_evt;
  assign long_evt    = (pstate == HELD) && !release_evt &&
                       (hold_cnt == HW'(LONG_PRESS_CYCLES - 1));

  assign accept            = gif.gesture_valid && ready_q;
  assign gif.gesture_ready = ready_q;

  always_comb begin
    vol_n  = volume;
    tens_n = freq_tens;
    ones_n = freq_ones;
    if (accept) begin
      case (mode)
        VOLUME: begin
          case (gif.gesture)
            UP:      vol_n = vol_up(volume);
            DOWN:    vol_n = vol_dn(volume);
            default: vol_n = volume;
          endcase
        end
        FREQ: begin
          case (gif.gesture)
            RIGHT: begin
              ones_n = dig_up(freq_ones);
              if (freq_ones == 4'd9) tens_n = dig_up(freq_tens);
            end
            LEFT: begin
              ones_n = dig_dn(freq_ones);
              if (freq_ones == 4'd0) tens_n = dig_dn(freq_tens);
            end
            UP:      tens_n = dig_up(freq_tens);
            DOWN:    tens_n = dig_dn(freq_tens);
            default: tens_n = freq_tens;
          endcase
        end
        default: vol_n = volume;
      endcase
    end
    // Long-press defaults take precedence over a coincident gesture.
    if (long_evt) begin
      vol_n  = 3'(VOL_DEFAULT);
      tens_n = TENS_DEF;
      ones_n = ONES_DEF;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pstate       <= IDLE;
      hold_cnt     <= '0;
      mode         <= GESTURE;
      volume       <= 3'(VOL_DEFAULT);
      volume_leds  <= thermo(3'(VOL_DEFAULT));
      freq_tens    <= TENS_DEF;
      freq_ones    <= ONES_DEF;
      last_gesture <= NONE;
      cfg_strobe   <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      case (pstate)
        IDLE: begin
          if (press_evt) begin
            pstate   <= HELD;
            hold_cnt <= '0;
          end
        end
        HELD: begin
          if (release_evt)   pstate   <= IDLE;
          else if (long_evt) pstate   <= LONG;
          else               hold_cnt <= hold_cnt + HW'(1);
        end
        LONG: begin
          if (release_evt) pstate <= IDLE;
        end
        default: pstate <= IDLE;
      endcase

      if (short_evt) mode <= next_mode(mode);
      if (accept)    last_gesture <= gif.gesture;
      // One intake slot per two cycles.
      ready_q     <= !accept;
      volume      <= vol_n;
      volume_leds <= thermo(vol_n);
      freq_tens   <= tens_n;
      freq_ones   <= ones_n;
      cfg_strobe  <= (vol_n != volume) || (tens_n != freq_tens) ||
                     (ones_n != freq_ones);
    end
  end
endmodule

// File: doc/av_control_unit.md
# av_control_unit

Control sequencer for the gesture AV board. It debounces the single user button into short and long press events, and steps the operating mode. It applies accepted gesture events to the volume level and the two-digit BCD frequency setting. It sits between the gesture decoder and the display drivers: the volume-LED and frequency-segment encoders take their values from this block.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a button level change.
- LONG_PRESS_CYCLES, 16: cycles the debounced button must stay held for a press to count as long.
- VOL_MAX, 7: saturating upper bound of volume.
- VOL_DEFAULT, 3: volume value at reset and after a long press.
- FREQ_DEFAULT, 50: frequency value (decimal, 0..99) at reset and after a long press.

Ports:
- Clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- button  in  1  raw push button, active-low (0 = pressed), asynchronous to Clock.
- gesture_valid  in  1  gesture event present.
- gesture  in  3  gesture_t code, qualified by gesture_valid.
- gesture_ready  out  1  block can accept a gesture this cycle.
- mode  out  2  current mode_t.
- volume  out  3  current volume, 0..VOL_MAX.
- volume_leds  out  7  thermometer code of volume; bit i = (volume > i).
- freq_tens  out  4  BCD tens digit.
- freq_ones  out  4  BCD ones digit.
- last_gesture  out  3  last accepted gesture code.
- cfg_strobe  out  1  one-cycle pulse after volume or frequency changed value.

## Operation
- Button path: 2-flop synchronizer, then a debounce counter. The debounced level flips only after DEBOUNCE_CYCLES consecutive samples differ from the current debounced level. Any matching sample clears the counter.
- Press FSM states: IDLE, HELD, LONG.
  - IDLE → HELD on the debounced press; the hold counter clears.
  - HELD → LONG when the hold counter reaches LONG_PRESS_CYCLES. This fires one long-press event.
  - HELD → IDLE on the debounced release; this fires one short-press event.
  - LONG → IDLE on the debounced release, with no event.
- Short press advances the mode: GESTURE → VOLUME → FREQ → GESTURE.
- Long press sets volume = VOL_DEFAULT and frequency = FREQ_DEFAULT. The mode is unchanged.
- Gesture handshake: a gesture is accepted when gesture_valid && gesture_ready. gesture_ready is registered and is 1 in every cycle after reset except the cycle immediately following an acceptance, which limits intake to one gesture per two cycles.
- Every accepted gesture writes last_gesture. The effect depends on the mode:
  - GESTURE: no other effect.
  - VOLUME: UP increments volume, saturating at VOL_MAX. DOWN decrements, saturating at 0. LEFT, RIGHT and NONE are ignored.
  - FREQ: RIGHT adds 1 and LEFT subtracts 1 (wrap 99→00, 00→99). UP adds 10 and DOWN subtracts 10, modulo 100 (95+10 = 05; 03−10 = 93). NONE is ignored.
- Frequency arithmetic is done digit-wise in BCD; both digits are always 0..9.
- cfg_strobe fires only when the stored value actually changes. A saturated no-op or a long press on values already at default gives no strobe.
- Simultaneous events:
  - Gesture accepted on the same edge as a short-press event: the gesture is applied under the old mode, and the mode advances on that same edge.
  - Gesture accepted on the same edge as a long-press event: the long-press defaults win for volume and frequency; last_gesture still updates.
- Reset mid-press or mid-handshake discards all state and restores the reset values.

## Timing
- Reset values:
  - mode = GESTURE; volume = VOL_DEFAULT; volume_leds = 7'b0000111.
  - freq_tens = 5, freq_ones = 0.
  - last_gesture = NONE; cfg_strobe = 0; gesture_ready = 0, rising to 1 on the first edge after release.
  - Press FSM = IDLE, with the debounced level = released.
- Button latency: the press/release edge is seen 2 + DEBOUNCE_CYCLES edges after the raw change. The mode updates on the edge that detects the release.
- Gesture latency: mode, volume, volume_leds, freq and last_gesture all update on the accepting edge. cfg_strobe is high for the single cycle after that edge.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package av_pkg:
  - mode_t (GESTURE=0, VOLUME=1, FREQ=2).
  - gesture_t (NONE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4).
  - press FSM state type.
- Sub-module button_debounce: synchronizer plus debounce counter, output debounced level. It is instantiated once.

## Test plan
- Reset, then idle → outputs: mode GESTURE, volume 3, leds 0000111, freq 5/0, gesture_ready 1 after first edge.
- Three short presses, each held 6 cycles → mode VOLUME, then FREQ, then GESTURE; each change lands exactly 6 edges after the release.
- VOLUME mode, 5 UP gestures → volume 7, leds 1111111, cfg_strobe on 4 of them only. Then 8 DOWN → volume 0, leds 0000000.
- FREQ mode sequence:
  - UP ×5 from 50 → 00.
  - LEFT → 99.
  - DOWN → 89.
  - RIGHT ×11 → 00.
- Button held 20 cycles with volume 6, freq 12 → volume 3, freq 50, mode unchanged, no mode step on release.
- Back-to-back gesture_valid for 4 cycles → only 2 accepted (ready alternates). A gesture on the short-press edge is applied under the old mode.
